quiz_round_engine: RTL and testbench
====================================

Name: quiz_round_engine

Overview:
- Multi-player, multi-round successor to the two-player quiz block: a parametrised round sequencer with a countdown timer, per-player answer latching, scoring and winner resolution.
- Sits between the random-number source (target request/valid handshake) and the per-player OLED/7-seg renderers, which consume its registered status outputs.
- Contains no pixel drawing; closeness is exported as a per-player absolute difference for colour mapping downstream.

Parameters:
- NUM_PLAYERS, 2, number of players (1-8).
- ANS_W, 8, answer/target width in bits.
- NUM_ROUNDS, 5, rounds per game (1-15).
- ROUND_SECS, 30, countdown reload value in tick_en strobes (1-255).
- SCORE_W, 6, per-player score width.
- FIRST_BONUS, 2, points for the first correct answer in a round. Every other correct answer scores 1.

Ports:
- basys3_clk  in  1  system clock; the only clock.
- quiz_reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a game from IDLE or DONE.
- tick_en  in  1  single-cycle 1 Hz strobe, synchronous to basys3_clk.
- target_in  in  ANS_W  target value from the RNG.
- target_valid  in  1  target_in is valid this cycle.
- target_req  out  1  single-cycle pulse requesting a new target.
- answers  in  NUM_PLAYERS*ANS_W  packed player answers; player i occupies [i*ANS_W +: ANS_W].
- submit  in  NUM_PLAYERS  per-player single-cycle submit pulses.
- state  out  3  IDLE=0, LOAD=1, RUN=2, SCORE=3, DONE=4.
- target  out  ANS_W  latched round target.
- time_left  out  8  remaining ticks in the round.
- round_num  out  4  current round, 0-based.
- locked  out  NUM_PLAYERS  player has answered correctly this round.
- scores  out  NUM_PLAYERS*SCORE_W  packed scores.
- diff  out  NUM_PLAYERS*ANS_W  |answer - target| per player, registered.
- round_done  out  1  single-cycle pulse on each SCORE cycle.
- game_over  out  1  high while in DONE.
- winner  out  3  index of the highest score; valid in DONE.
- tie  out  1  more than one player holds the maximum score; valid in DONE.

Behaviour:
- Reset (sampled on the basys3_clk edge):
  - state=IDLE.
  - All outputs 0: target, time_left, round_num, locked, scores, diff, target_req, round_done, game_over, winner, tie.
  - Reset during any state aborts the game immediately. A pending target_valid is discarded.
- IDLE: start -> LOAD. Scores and round_num are cleared on this transition.
- LOAD:
  - target_req pulses for exactly one cycle, the cycle after entry.
  - Stays in LOAD until target_valid=1. That cycle: latch target_in into target, time_left<=ROUND_SECS, locked<=0, next state RUN.
  - target_valid seen in any other state is ignored.
- RUN:
  - tick_en with time_left>0 decrements time_left.
  - When time_left reaches 0, or all bits of locked are set, go to SCORE on the next cycle.
  - Decrement-to-0 and the last lock in the same cycle produce a single SCORE entry.
- Submissions (RUN only):
  - submit[i] with locked[i]=0 compares answers[i] to target, full ANS_W width, unsigned.
  - Equal: locked[i]<=1 and the score is added.
  - First correct answer in the round gets FIRST_BONUS. If several players submit correctly in the same cycle, the lowest index gets FIRST_BONUS and the others get 1.
  - Scores saturate at 2^SCORE_W-1.
  - Wrong answers leave the player unlocked; retries are allowed.
  - Submits while locked or outside RUN have no effect.
- SCORE:
  - Lasts one cycle; round_done=1.
  - If round_num==NUM_ROUNDS-1 -> DONE; else round_num+1 and go to LOAD.
- DONE:
  - game_over=1. winner and tie are computed from final scores and registered on DONE entry.
  - Ties resolve to the lowest index, with tie=1.
  - start -> LOAD: scores cleared, round_num=0, game_over cleared. Otherwise DONE holds.
- start in LOAD, RUN or SCORE is ignored.
- diff[i] updates every cycle from the current answers[i] and target, one-cycle latency, in all states.
- All outputs are registered; nothing is combinational from inputs.

Optional Feature:
- QUIZ_PENALTY_EN defined: a wrong submission in RUN by an unlocked player decrements that player's score by 1, saturating at 0. If a wrong and a correct submission coincide across players, each is applied independently.
- Not defined: wrong submissions do not change scores.

Test Plan:
- Reset then start; target_valid with target_in=0x2A one cycle after target_req -> target=0x2A, state=RUN, time_left=30.
- NUM_PLAYERS=2; both submit 0x2A in the same cycle -> scores {p0=2, p1=1}, locked=11, SCORE on the next cycle, round_done pulses once.
- No submits; 30 tick_en strobes -> time_left 30->0, then SCORE, round_num increments, new target_req pulse.
- Play 5 rounds with p1 always first correct -> DONE, game_over=1, winner=1, tie=0. Equal scores instead -> winner=0, tie=1.
- quiz_reset asserted mid-RUN with time_left=12 and nonzero scores -> the next cycle shows all outputs 0, state=IDLE. Submits are then ignored until start.
- With QUIZ_PENALTY_EN: p0 at score 0 submits a wrong value -> score stays 0. At score 3, a wrong submit -> 2. Without the macro -> 3.

Source files
------------

// File: rtl/quiz_round_engine.sv
// Multi-player quiz round sequencer: countdown, per-player answer latching, scoring, winner pick.
// Optional macro QUIZ_PENALTY_EN: wrong submissions in RUN cost one point (floored at 0).
module quiz_round_engine #(
  parameter int NUM_PLAYERS = 2,
  parameter int ANS_W       = 8,
  parameter int NUM_ROUNDS  = 5,
  parameter int ROUND_SECS  = 30,
  parameter int SCORE_W     = 6,
  parameter int FIRST_BONUS = 2
) (
  input  logic                         basys3_clk,
  input  logic                         quiz_reset,
  input  logic                         start,
  input  logic                         tick_en,
  input  logic [ANS_W-1:0]             target_in,
  input  logic                         target_valid,
  output logic                         target_req,
  input  logic [NUM_PLAYERS*ANS_W-1:0] answers,
  input  logic [NUM_PLAYERS-1:0]       submit,
  output logic [2:0]                   state,
  output logic [ANS_W-1:0]             target,
  output logic [7:0]                   time_left,
  output logic [3:0]                   round_num,
  output logic [NUM_PLAYERS-1:0]       locked,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [NUM_PLAYERS*ANS_W-1:0] diff,
  output logic                         round_done,
  output logic                         game_over,
  output logic [2:0]                   winner,
  output logic                         tie
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    SCORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0]         RELOAD     = 8'(ROUND_SECS);
  localparam logic [3:0]         LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [SCORE_W:0]   BONUS      = (SCORE_W + 1)'(FIRST_BONUS);
  localparam logic [SCORE_W:0]   ONE        = (SCORE_W + 1)'(1);

  state_t st;

  logic [NUM_PLAYERS-1:0]         locked_nxt;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_nxt;
  logic [7:0]                     time_nxt;
  logic                           to_score;
  logic                           bonus_free;
  logic [SCORE_W-1:0]             best;
  logic [2:0]                     best_idx;
  logic [3:0]                     n_max;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W:0]   b);
    logic [SCORE_W+1:0] s;
    s = {2'b00, a} + {1'b0, b};
    if (s > {2'b00, {SCORE_W{1'b1}}}) sat_add = '1;
    else                              sat_add = s[SCORE_W-1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] a);
    sat_dec = (a == '0) ? '0 : a - 1'b1;
  endfunction

  function automatic logic [ANS_W-1:0] abs_diff(input logic [ANS_W-1:0] a,
                                                input logic [ANS_W-1:0] b);
    logic signed [ANS_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    abs_diff = d[ANS_W] ? ANS_W'(-d) : d[ANS_W-1:0];
  endfunction

  // Submission resolution: ascending index order hands the bonus to the lowest correct player.
  always_comb begin
    locked_nxt = locked;
    scores_nxt = scores;
    bonus_free = (locked == '0);
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (st == RUN && submit[i] && !locked[i]) begin
        if (answers[i*ANS_W +: ANS_W] == target) begin
          locked_nxt[i] = 1'b1;
          scores_nxt[i*SCORE_W +: SCORE_W] =
            sat_add(scores[i*SCORE_W +: SCORE_W], bonus_free ? BONUS : ONE);
          bonus_free = 1'b0;
        end
`ifdef QUIZ_PENALTY_EN
        else begin
          scores_nxt[i*SCORE_W +: SCORE_W] = sat_dec(scores[i*SCORE_W +: SCORE_W]);
        end
`endif
      end
    end
    time_nxt = (st == RUN && tick_en && time_left != 8'd0) ? time_left - 8'd1 : time_left;
    to_score = (time_nxt == 8'd0) || (&locked_nxt);
  end

  // Winner is the first player reaching the maximum, so ties fall to the lowest index.
  always_comb begin
    best     = '0;
    best_idx = 3'd0;
    n_max    = 4'd0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (scores[i*SCORE_W +: SCORE_W] > best) begin
        best     = scores[i*SCORE_W +: SCORE_W];
        best_idx = 3'(i);
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (scores[i*SCORE_W +: SCORE_W] == best) n_max = n_max + 4'd1;
    end
  end

  always_ff @(posedge basys3_clk) begin
    if (quiz_reset) begin
      st         <= IDLE;
      target     <= '0;
      time_left  <= '0;
      round_num  <= '0;
      locked     <= '0;
      scores     <= '0;
      diff       <= '0;
      target_req <= 1'b0;
      round_done <= 1'b0;
      game_over  <= 1'b0;
      winner     <= '0;
      tie        <= 1'b0;
    end else begin
      target_req <= 1'b0;
      round_done <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++)
        diff[i*ANS_W +: ANS_W] <= abs_diff(answers[i*ANS_W +: ANS_W], target);
      case (st)
        IDLE: if (start) begin
          st         <= LOAD;
          scores     <= '0;
          round_num  <= '0;
          target_req <= 1'b1;
        end
        LOAD: if (target_valid) begin
          target    <= target_in;
          time_left <= RELOAD;
          locked    <= '0;
          st        <= RUN;
        end
        RUN: begin
          locked    <= locked_nxt;
          scores    <= scores_nxt;
          time_left <= time_nxt;
          if (to_score) begin
            st         <= SCORE;
            round_done <= 1'b1;
          end
        end
        SCORE: if (round_num == LAST_ROUND) begin
          st        <= DONE;
          game_over <= 1'b1;
          winner    <= best_idx;
          tie       <= (n_max > 4'd1);
        end else begin
          round_num  <= round_num + 4'd1;
          st         <= LOAD;
          target_req <= 1'b1;
        end
        DONE: if (start) begin
          st         <= LOAD;
          scores     <= '0;
          round_num  <= '0;
          game_over  <= 1'b0;
          target_req <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_quiz_round_engine.sv
// Bench for quiz_round_engine: directed vector table, hand sequences, and randomized play
// checked every cycle against a behavioural model of the game rules.
module tb_quiz_round_engine;

  localparam int NP = 2;
  localparam int AW = 8;
  localparam int SW = 6;
  localparam int NR = 5;
  localparam int RS = 30;
  localparam int FB = 2;
  localparam int SMAX = (1 << SW) - 1;
`ifdef QUIZ_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk;
  logic quiz_reset, start, tick_en, target_valid, target_req;
  logic [AW-1:0] target_in;
  logic [NP*AW-1:0] answers;
  logic [NP-1:0] submit;
  logic [2:0] state;
  logic [AW-1:0] target;
  logic [7:0] time_left;
  logic [3:0] round_num;
  logic [NP-1:0] locked;
  logic [NP*SW-1:0] scores;
  logic [NP*AW-1:0] diff;
  logic round_done, game_over, tie;
  logic [2:0] winner;

  quiz_round_engine dut (
    .basys3_clk(clk), .quiz_reset(quiz_reset), .start(start), .tick_en(tick_en),
    .target_in(target_in), .target_valid(target_valid), .target_req(target_req),
    .answers(answers), .submit(submit), .state(state), .target(target),
    .time_left(time_left), .round_num(round_num), .locked(locked), .scores(scores),
    .diff(diff), .round_done(round_done), .game_over(game_over), .winner(winner), .tie(tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model of the game, kept as plain integers per the rules.
  int m_state, m_target, m_time, m_round, m_win;
  bit m_req, m_rdone, m_over, m_tie;
  bit m_locked[NP];
  int m_score[NP];
  int m_diff[NP];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int ans[NP];
    int nd[NP];
    bit first_ok, all_locked;
    int best, cnt;
    for (int i = 0; i < NP; i++) begin
      ans[i] = int'(answers[i*AW +: AW]);
      nd[i]  = (ans[i] > m_target) ? ans[i] - m_target : m_target - ans[i];
    end
    if (quiz_reset) begin
      m_state = 0; m_target = 0; m_time = 0; m_round = 0; m_win = 0;
      m_req = 0; m_rdone = 0; m_over = 0; m_tie = 0;
      for (int i = 0; i < NP; i++) begin
        m_locked[i] = 0; m_score[i] = 0; m_diff[i] = 0;
      end
      return;
    end
    m_req = 0;
    m_rdone = 0;
    case (m_state)
      0, 4: if (start) begin
        m_state = 1; m_round = 0; m_req = 1; m_over = 0;
        for (int i = 0; i < NP; i++) m_score[i] = 0;
      end
      1: if (target_valid) begin
        m_target = int'(target_in); m_time = RS; m_state = 2;
        for (int i = 0; i < NP; i++) m_locked[i] = 0;
      end
      2: begin
        first_ok = 1;
        for (int i = 0; i < NP; i++) if (m_locked[i]) first_ok = 0;
        for (int i = 0; i < NP; i++) begin
          if (submit[i] && !m_locked[i]) begin
            if (ans[i] == m_target) begin
              m_locked[i] = 1;
              m_score[i] = m_score[i] + (first_ok ? FB : 1);
              if (m_score[i] > SMAX) m_score[i] = SMAX;
              first_ok = 0;
            end else if (PEN && m_score[i] > 0) begin
              m_score[i] = m_score[i] - 1;
            end
          end
        end
        if (tick_en && m_time > 0) m_time = m_time - 1;
        all_locked = 1;
        for (int i = 0; i < NP; i++) if (!m_locked[i]) all_locked = 0;
        if (m_time == 0 || all_locked) begin
          m_state = 3; m_rdone = 1;
        end
      end
      3: if (m_round == NR - 1) begin
        m_state = 4; m_over = 1;
        best = -1; cnt = 0;
        for (int i = 0; i < NP; i++) if (m_score[i] > best) begin best = m_score[i]; m_win = i; end
        for (int i = 0; i < NP; i++) if (m_score[i] == best) cnt++;
        m_tie = (cnt > 1);
      end else begin
        m_round = m_round + 1; m_state = 1; m_req = 1;
      end
      default: ;
    endcase
    for (int i = 0; i < NP; i++) m_diff[i] = nd[i];
  endtask

  task automatic compare_model();
    int pl, ps, pd;
    pl = 0; ps = 0; pd = 0;
    for (int i = 0; i < NP; i++) begin
      pl = pl + (int'(m_locked[i]) << i);
      ps = ps + (m_score[i] << (i * SW));
      pd = pd + (m_diff[i] << (i * AW));
    end
    chk("m_state", int'(state), m_state);
    chk("m_target", int'(target), m_target);
    chk("m_time_left", int'(time_left), m_time);
    chk("m_round_num", int'(round_num), m_round);
    chk("m_locked", int'(locked), pl);
    chk("m_scores", int'(scores), ps);
    chk("m_diff", int'(diff), pd);
    chk("m_target_req", int'(target_req), int'(m_req));
    chk("m_round_done", int'(round_done), int'(m_rdone));
    chk("m_game_over", int'(game_over), int'(m_over));
    if (m_over) begin
      chk("m_winner", int'(winner), m_win);
      chk("m_tie", int'(tie), int'(m_tie));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic idle_in();
    quiz_reset = 0; start = 0; tick_en = 0; target_valid = 0;
    target_in = '0; answers = '0; submit = '0;
  endtask

  // Entered in LOAD; leaves in LOAD (next round) or DONE.
  // order 0: p0 then p1 correct, 1: p1 then p0, 2: nobody answers (timeout).
  task automatic play_round(input int order, input logic [AW-1:0] t);
    idle_in(); target_valid = 1; target_in = t; cyc(); idle_in();
    if (order == 2) begin
      tick_en = 1;
      repeat (RS) cyc();
      idle_in();
    end else begin
      answers = {NP{t}};
      submit = '0; submit[order] = 1'b1; cyc();
      submit = '0; submit[1-order] = 1'b1; cyc();
      idle_in();
    end
    cyc();
  endtask

  typedef struct {
    bit rst, st, tk, tv;
    logic [7:0] tin, a0, a1;
    logic [1:0] sub;
    int e_state, e_target, e_time, e_round;
    logic [1:0] e_locked;
    int e_s0, e_s1;
    bit e_req, e_rdone;
  } vec_t;

  vec_t vecs[12];
  int p;

  initial begin
    p = int'(PEN);
    idle_in();
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00,2'b00, 0,0,0,0, 2'b00,0,0, 1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0, 8'h00,8'h00,8'h00,2'b00, 1,0,0,0, 2'b00,0,0, 1'b1,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00,2'b00, 1,0,0,0, 2'b00,0,0, 1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1, 8'h2A,8'h00,8'h00,2'b00, 2,42,30,0, 2'b00,0,0, 1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b0, 8'h00,8'h00,8'h00,2'b00, 2,42,29,0, 2'b00,0,0, 1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0, 8'h00,8'h2A,8'h2A,2'b11, 3,42,29,0, 2'b11,2,1, 1'b0,1'b1};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00,2'b00, 1,42,29,1, 2'b11,2,1, 1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1, 8'h10,8'h00,8'h00,2'b00, 2,16,30,1, 2'b00,2,1, 1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0, 8'h00,8'h11,8'h00,2'b01, 2,16,30,1, 2'b00,2-p,1, 1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b1,1'b0, 8'h00,8'h00,8'h10,2'b10, 2,16,29,1, 2'b10,2-p,3, 1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0, 8'h00,8'h10,8'h10,2'b11, 3,16,29,1, 2'b11,3-p,3, 1'b0,1'b1};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0, 8'h00,8'h00,8'h00,2'b00, 1,16,29,2, 2'b11,3-p,3, 1'b1,1'b0};

    repeat (2) @(posedge clk);
    #1;
    for (int v = 0; v < 12; v++) begin
      quiz_reset = vecs[v].rst; start = vecs[v].st; tick_en = vecs[v].tk;
      target_valid = vecs[v].tv; target_in = vecs[v].tin;
      answers = {vecs[v].a1, vecs[v].a0}; submit = vecs[v].sub;
      cyc();
      chk("vec_state", int'(state), vecs[v].e_state);
      chk("vec_target", int'(target), vecs[v].e_target);
      chk("vec_time_left", int'(time_left), vecs[v].e_time);
      chk("vec_round_num", int'(round_num), vecs[v].e_round);
      chk("vec_locked", int'(locked), int'(vecs[v].e_locked));
      chk("vec_score0", int'(scores[SW-1:0]), vecs[v].e_s0);
      chk("vec_score1", int'(scores[2*SW-1:SW]), vecs[v].e_s1);
      chk("vec_target_req", int'(target_req), int'(vecs[v].e_req));
      chk("vec_round_done", int'(round_done), int'(vecs[v].e_rdone));
    end
    idle_in();

    // Timeout round: 30 consecutive ticks run the clock out.
    target_valid = 1; target_in = 8'h55; cyc(); idle_in();
    chk("to_time_reload", int'(time_left), 30);
    tick_en = 1;
    for (int k = 1; k <= RS; k++) begin
      cyc();
      chk("to_time_count", int'(time_left), RS - k);
    end
    idle_in();
    chk("to_score_state", int'(state), 3);
    chk("to_round_done", int'(round_done), 1);
    cyc();
    chk("to_next_load", int'(state), 1);
    chk("to_round_inc", int'(round_num), 3);
    chk("to_target_req", int'(target_req), 1);

    // Full game, p1 always first correct.
    quiz_reset = 1; cyc(); idle_in();
    start = 1; cyc(); idle_in();
    for (int r = 0; r < NR; r++) play_round(1, 8'(r * 7 + 3));
    chk("g1_state_done", int'(state), 4);
    chk("g1_game_over", int'(game_over), 1);
    chk("g1_winner", int'(winner), 1);
    chk("g1_tie", int'(tie), 0);
    chk("g1_scores", int'(scores), (10 << SW) | 5);
    cyc();
    chk("g1_done_holds", int'(state), 4);

    // Tied game restarted from DONE.
    start = 1; cyc(); idle_in();
    chk("g2_restart_load", int'(state), 1);
    chk("g2_scores_clr", int'(scores), 0);
    chk("g2_over_clr", int'(game_over), 0);
    play_round(0, 8'h11); play_round(0, 8'h22);
    play_round(1, 8'h33); play_round(1, 8'h44);
    play_round(2, 8'h55);
    chk("g2_state_done", int'(state), 4);
    chk("g2_winner", int'(winner), 0);
    chk("g2_tie", int'(tie), 1);

    // Reset mid-RUN at time_left 12 with a nonzero score.
    start = 1; cyc(); idle_in();
    target_valid = 1; target_in = 8'h33; cyc(); idle_in();
    answers = {8'h00, 8'h33}; submit = 2'b01; cyc(); idle_in();
    tick_en = 1; repeat (18) cyc(); idle_in();
    chk("rst_pre_time", int'(time_left), 12);
    chk("rst_pre_score", int'(scores[SW-1:0]), 2);
    quiz_reset = 1; answers = {8'h33, 8'h33}; submit = 2'b11; cyc();
    chk("rst_state", int'(state), 0);
    chk("rst_target", int'(target), 0);
    chk("rst_time", int'(time_left), 0);
    chk("rst_round", int'(round_num), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_scores", int'(scores), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_req", int'(target_req), 0);
    chk("rst_round_done", int'(round_done), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_tie", int'(tie), 0);
    quiz_reset = 0; target_valid = 1; target_in = 8'h33;
    repeat (3) begin
      cyc();
      chk("idle_state", int'(state), 0);
      chk("idle_scores", int'(scores), 0);
      chk("idle_locked", int'(locked), 0);
    end
    idle_in();

    // Wrong submissions: floor at 0, and 3 -> 2 only with the penalty build.
    start = 1; cyc(); idle_in();
    target_valid = 1; target_in = 8'h40; cyc(); idle_in();
    answers = {8'h00, 8'h41}; submit = 2'b01; cyc(); idle_in();
    chk("pen_floor", int'(scores[SW-1:0]), 0);
    chk("pen_unlocked", int'(locked), 0);
    answers = {8'h40, 8'h40}; submit = 2'b01; cyc(); submit = 2'b10; cyc(); idle_in(); cyc();
    play_round(1, 8'h21);
    chk("pen_pre_score", int'(scores[SW-1:0]), 3);
    target_valid = 1; target_in = 8'h77; cyc(); idle_in();
    answers = {8'h00, 8'h78}; submit = 2'b01; cyc(); idle_in();
    chk("pen_wrong", int'(scores[SW-1:0]), 3 - p);

    // Randomized play against the model.
    quiz_reset = 1; cyc(); idle_in();
    for (int n = 0; n < 4000; n++) begin
      quiz_reset = ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 7) == 0);
      tick_en = ($urandom_range(0, 2) == 0);
      target_valid = ($urandom_range(0, 3) == 0);
      target_in = 8'($urandom_range(0, 255));
      for (int i = 0; i < NP; i++) begin
        answers[i*AW +: AW] = ($urandom_range(0, 1) == 1) ? 8'(m_target) : 8'($urandom_range(0, 255));
        submit[i] = ($urandom_range(0, 2) == 0);
      end
      cyc();
    end
    idle_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
